// File: rtl/clk_edge_tracker_pkg.sv
// Shared definitions for the slow-clock tracker and the life engine that consumes its lock status.
package clk_edge_tracker_pkg;

    typedef enum logic [1:0] {
        ST_START   = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } state_t;

    // Both sides must agree on these so generation updates gate on the same notion of "stable".
    localparam int unsigned DEF_TIMEOUT = 1024;
    localparam int unsigned DEF_TOL     = 1;

endpackage

// File: rtl/clk_edge_tracker_if.sv
// Slow-clock input and tracker status outputs; slave is the tracker side, master the consumer/driver.
interface clk_edge_tracker_if #(
    parameter int unsigned CNT_W = 16
);
    logic             i_slow;
    logic             o_rise;
    logic             o_fall;
    logic [CNT_W-1:0] o_period;
    logic             o_period_vld;
    logic             o_locked;
    logic             o_lost;

    modport slave (
        input  i_slow,
        output o_rise, o_fall, o_period, o_period_vld, o_locked, o_lost
    );

    modport master (
        output i_slow,
        input  o_rise, o_fall, o_period, o_period_vld, o_locked, o_lost
    );
endinterface

// File: rtl/clk_edge_tracker_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level with registered one-cycle rise/fall pulses.
module clk_edge_tracker_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise_now,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    logic                   level;
    logic                   prev;
    logic                   fall_now;

    assign level    = sync[SYNC_STAGES-1];
    // rise_now is the unregistered edge, exported so period logic acts in the same cycle o_rise is set.
    assign rise_now = level & ~prev;
    assign fall_now = ~level & prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], din};
            prev <= level;
            rise <= rise_now;
            fall <= fall_now;
        end
    end
endmodule

// File: rtl/clk_edge_tracker.sv
// Tracks a slow free-running clock in the i_clk domain: edge pulses, period measurement, lock/loss FSM.
module clk_edge_tracker
    import clk_edge_tracker_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned LOCK_EDGES  = 4,
    parameter int unsigned TOL         = DEF_TOL,
    parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
    input logic               i_clk,
    input logic               i_rst_n,
    clk_edge_tracker_if.slave bus
);
    localparam int unsigned MATCH_W = $clog2(LOCK_EDGES + 1);

    logic                     rise_now;
    logic                     rise_q;
    logic                     fall_q;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         measured;
    logic [CNT_W-1:0]         period;
    logic signed [CNT_W:0]    diff;
    logic [CNT_W:0]           diff_abs;
    logic                     in_tol;
    logic                     timeout_hit;
    logic [MATCH_W-1:0]       match;
    logic [MATCH_W-1:0]       match_inc;
    state_t                   state;
    logic                     period_vld;
    logic                     locked;
    logic                     lost;

    clk_edge_tracker_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .din      (bus.i_slow),
        .rise_now (rise_now),
        .rise     (rise_q),
        .fall     (fall_q)
    );

    always_comb begin
        measured    = (&cnt) ? cnt : cnt + CNT_W'(1);
        diff        = $signed({1'b0, measured}) - $signed({1'b0, period});
        diff_abs    = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
        in_tol      = period_vld && (diff_abs <= (CNT_W+1)'(TOL));
        // A rise in the timeout cycle takes priority over declaring loss.
        timeout_hit = !rise_now && (cnt == CNT_W'(TIMEOUT - 1));
        match_inc   = (match == MATCH_W'(LOCK_EDGES)) ? match : match + MATCH_W'(1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (rise_now) begin
            cnt <= '0;
        end else if (!(&cnt)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_START;
            period     <= '0;
            period_vld <= 1'b0;
            locked     <= 1'b0;
            lost       <= 1'b0;
            match      <= '0;
        end else if (rise_now) begin
            case (state)
                ST_ACQUIRE: begin
                    period     <= measured;
                    period_vld <= 1'b1;
                    if (in_tol) begin
                        match <= match_inc;
                        if (match_inc == MATCH_W'(LOCK_EDGES)) begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                        end
                    end else begin
                        match <= '0;
                    end
                end
                ST_LOCKED: begin
                    period <= measured;
                    if (!in_tol) begin
                        state  <= ST_ACQUIRE;
                        locked <= 1'b0;
                        match  <= '0;
                    end
                end
                default: begin
                    // START/LOST: this edge only becomes the reference for the next measurement.
                    state <= ST_ACQUIRE;
                    lost  <= 1'b0;
                    match <= '0;
                end
            endcase
        end else if (timeout_hit) begin
            state      <= ST_LOST;
            lost       <= 1'b1;
            period_vld <= 1'b0;
            locked     <= 1'b0;
            match      <= '0;
        end
    end

    assign bus.o_rise       = rise_q;
    assign bus.o_fall       = fall_q;
    assign bus.o_period     = period;
    assign bus.o_period_vld = period_vld;
    assign bus.o_locked     = locked;
    assign bus.o_lost       = lost;
endmodule
